mem_store_buffer: RTL and testbench
===================================

MEM_STORE_BUFFER -- requirements
Module: mem_store_buffer

Interface
REQ-001 Parameter DEPTH, default 4, SHALL set the number of buffered stores and is restricted to powers of two in the range 2..16.
REQ-002 Parameter AW, default 32, SHALL set the address width.
REQ-003 Parameter DW, default 32, SHALL set the data width.
REQ-004 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 reset  input  1  SHALL be the synchronous, active-high reset.
REQ-006 MemWriteM  input  1  SHALL be the CPU memory-stage store request.
REQ-007 DataAdrM  input  AW  SHALL be the CPU store/load byte address.
REQ-008 WriteDataM  input  DW  SHALL be the CPU store data.
REQ-009 MemReadM  input  1  SHALL be the CPU memory-stage load request, used for forwarding lookup.
REQ-010 StallM  output  1  SHALL tell the CPU to hold its memory stage because the store was not accepted.
REQ-011 FwdHitM  output  1  SHALL indicate that a buffered store matches the load address.
REQ-012 FwdDataM  output  DW  SHALL carry the forwarded store data.
REQ-013 mem_req  output  1  SHALL be the request to data memory.
REQ-014 mem_addr  output  AW  SHALL be the address of the head entry.
REQ-015 mem_wdata  output  DW  SHALL be the data of the head entry.
REQ-016 mem_ack  input  1  SHALL be the data memory's completion of the current request.
REQ-017 count  output  $clog2(DEPTH)+1  SHALL be the number of valid entries.
REQ-018 empty  output  1  SHALL be high when count equals 0.

Function
REQ-019 The buffer SHALL be a circular FIFO with write pointer wp and read pointer rp, each wrapping modulo DEPTH.
REQ-020 push SHALL equal MemWriteM and (count < DEPTH); on push, {DataAdrM, WriteDataM} SHALL be written at wp and wp SHALL advance.
REQ-021 StallM SHALL equal MemWriteM and (count == DEPTH), computed combinationally from registered count, with no same-cycle bypass of a pop.
REQ-022 mem_req SHALL equal (count != 0), and mem_addr/mem_wdata SHALL equal the entry at rp.
REQ-023 pop SHALL equal mem_req and mem_ack; on pop, rp SHALL advance.
REQ-024 While mem_req is high and mem_ack is low, mem_addr and mem_wdata SHALL be held stable.
REQ-025 mem_ack while count == 0 SHALL be ignored.
REQ-026 On simultaneous push and pop, count SHALL be unchanged and both pointers SHALL advance.
REQ-027 count SHALL change by +1 on push only, by -1 on pop only, and never exceed DEPTH or go below 0.
REQ-028 Stores SHALL drain to memory in exact acceptance order, with latency of at least 1 cycle from push to the first mem_req for that entry.
REQ-029 When MemReadM is high, FwdHitM SHALL be high if any valid entry's address matches DataAdrM on bits [AW-1:2] (word compare), combinationally.
REQ-030 On multiple matches, FwdDataM SHALL return the youngest entry, i.e. the one closest to wp.
REQ-031 An entry popped in the current cycle SHALL still participate in the match; a store pushed in the current cycle SHALL NOT.
REQ-032 When MemReadM is low or there is no match, FwdHitM SHALL be 0 and FwdDataM SHALL be 0.

Reset
REQ-033 While reset is high at a rising edge, wp, rp and count SHALL become 0; next cycle empty=1, mem_req=0, StallM=0, FwdHitM=0.
REQ-034 A reset during a pending mem_req SHALL discard all entries; a mem_ack in the reset cycle SHALL be ignored.
REQ-035 Entry storage SHALL NOT require reset; only valid state is cleared.

Verification
REQ-036 Push store (0x10, 0xAAAA0001) with mem_ack held low -> next cycle mem_req=1, mem_addr=0x10, mem_wdata=0xAAAA0001, count=1; these stay stable for 5 cycles.
REQ-037 Five back-to-back stores with mem_ack=0 and DEPTH=4 -> count=4; the fifth store has StallM=1 until one ack, then is accepted the cycle after.
REQ-038 Full buffer, then push and ack in the same cycle -> StallM=1, only the pop occurs, count=3; the store is accepted on the next cycle.
REQ-039 Stores to 0x20 (0x1) then 0x20 (0x2), then a load of 0x22 -> FwdHitM=1, FwdDataM=0x2; a load of 0x24 -> FwdHitM=0.
REQ-040 Eight stores with addresses 0x0..0x1C and ack every other cycle -> memory sees the addresses in order across pointer wrap, and count returns to 0 with empty=1.
REQ-041 Three entries valid, reset asserted one cycle with mem_ack=1 -> count=0, mem_req=0, and no further memory writes.

Source files
------------

// File: rtl/mem_store_buffer_if.sv
// Store-buffer bus bundle.
// Groups the CPU memory-stage signals and the data-memory handshake that
// connect to mem_store_buffer.
//   CPU side : MemWriteM, DataAdrM, WriteDataM, MemReadM  (to buffer)
//              StallM, FwdHitM, FwdDataM                  (from buffer)
//   Mem side : mem_req, mem_addr, mem_wdata               (from buffer)
//              mem_ack                                    (to buffer)
// Modports:
//   slave  - the buffer's view
//   master - the environment's view (CPU pipeline + data memory)
interface mem_store_buffer_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          MemWriteM;
  logic [AW-1:0] DataAdrM;
  logic [DW-1:0] WriteDataM;
  logic          MemReadM;
  logic          StallM;
  logic          FwdHitM;
  logic [DW-1:0] FwdDataM;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ack;

  modport slave (
    input  MemWriteM, DataAdrM, WriteDataM, MemReadM, mem_ack,
    output StallM, FwdHitM, FwdDataM, mem_req, mem_addr, mem_wdata
  );

  modport master (
    output MemWriteM, DataAdrM, WriteDataM, MemReadM, mem_ack,
    input  StallM, FwdHitM, FwdDataM, mem_req, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_store_buffer.sv
// In-order store buffer between the CPU memory stage and data memory.
// Accepted stores are queued in a circular FIFO and drained to memory one
// at a time through a req/ack handshake. Loads look up the buffered stores
// by word address and receive the youngest matching data.
// Ports:
//   clk    - clock, all state updates on the rising edge
//   reset  - synchronous active-high reset (clears pointers and count)
//   bus    - mem_store_buffer_if.slave (CPU store/load + memory handshake)
//   count  - number of valid entries
//   empty  - high when count is zero
module mem_store_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  mem_store_buffer_if.slave        bus,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  // Entry storage carries no reset; validity comes from rp/count alone.
  logic [AW-1:0] addr_q [DEPTH];
  logic [DW-1:0] data_q [DEPTH];

  logic [PW-1:0] wp_q, wp_d;
  logic [PW-1:0] rp_q, rp_d;
  logic [CW-1:0] count_q, count_d;

  logic full;
  logic push;
  logic pop;

  // Full is taken from the registered count only: a pop in the same cycle
  // does not free a slot until the next cycle.
  assign full = (count_q == CW'(DEPTH));
  assign push = bus.MemWriteM && !full;
  assign pop  = (count_q != '0) && bus.mem_ack;

  always_comb begin
    wp_d    = wp_q;
    rp_d    = rp_q;
    count_d = count_q;
    if (push) wp_d = wp_q + PW'(1);
    if (pop)  rp_d = rp_q + PW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wp_q    <= '0;
      rp_q    <= '0;
      count_q <= '0;
    end else begin
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[wp_q] <= bus.DataAdrM;
      data_q[wp_q] <= bus.WriteDataM;
    end
  end

  // Forwarding: walk entries from oldest (rp) to youngest so that the last
  // match wins. Only registered entries are searched, so a store being
  // pushed this cycle is invisible while one being popped still counts.
  logic          fwd_hit;
  logic [DW-1:0] fwd_data;
  logic [PW-1:0] idx;

  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    idx      = '0;
    if (bus.MemReadM) begin
      for (int k = 0; k < DEPTH; k++) begin
        idx = rp_q + PW'(k);
        if ((CW'(k) < count_q) &&
            (addr_q[idx][AW-1:2] == bus.DataAdrM[AW-1:2])) begin
          fwd_hit  = 1'b1;
          fwd_data = data_q[idx];
        end
      end
    end
  end

  assign bus.StallM    = bus.MemWriteM && full;
  assign bus.FwdHitM   = fwd_hit;
  assign bus.FwdDataM  = fwd_data;
  assign bus.mem_req   = (count_q != '0);
  assign bus.mem_addr  = addr_q[rp_q];
  assign bus.mem_wdata = data_q[rp_q];

  assign count = count_q;
  assign empty = (count_q == '0);
endmodule

// File: tb/tb_mem_store_buffer.sv
module tb_mem_store_buffer;
  localparam int DEPTH = 4;
  localparam int AW    = 32;
  localparam int DW    = 32;

  logic clk;
  logic reset;
  logic [$clog2(DEPTH):0] count;
  logic empty;

  int checks;
  int errors;

  logic [AW-1:0] seen_addr [$];
  logic [DW-1:0] seen_data [$];

  mem_store_buffer_if #(.AW(AW), .DW(DW)) sb ();

  mem_store_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (sb),
    .count (count),
    .empty (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every completed memory write outside of reset.
  always @(posedge clk) begin
    if (!reset && sb.mem_req && sb.mem_ack) begin
      seen_addr.push_back(sb.mem_addr);
      seen_data.push_back(sb.mem_wdata);
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int sent;
    logic acc;
    checks = 0;
    errors = 0;
    reset = 1'b1;
    sb.MemWriteM  = 1'b0;
    sb.DataAdrM   = '0;
    sb.WriteDataM = '0;
    sb.MemReadM   = 1'b0;
    sb.mem_ack    = 1'b0;
    tick();
    tick();

    // Reset state
    reset = 1'b0;
    sb.MemReadM = 1'b1;
    #1;
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_req", sb.mem_req, 0);
    chk("rst_stall", sb.StallM, 0);
    chk("rst_fwdhit", sb.FwdHitM, 0);
    sb.MemReadM = 1'b0;

    // Single store held without ack
    sb.MemWriteM = 1'b1; sb.DataAdrM = 32'h10; sb.WriteDataM = 32'hAAAA0001;
    #1;
    chk("s1_stall", sb.StallM, 0);
    chk("s1_req_same_cycle", sb.mem_req, 0);
    tick();
    sb.MemWriteM = 1'b0;
    #1;
    chk("s1_req", sb.mem_req, 1);
    chk("s1_addr", sb.mem_addr, 32'h10);
    chk("s1_wdata", sb.mem_wdata, 32'hAAAA0001);
    chk("s1_count", count, 1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("s1_hold_req", sb.mem_req, 1);
      chk("s1_hold_addr", sb.mem_addr, 32'h10);
      chk("s1_hold_wdata", sb.mem_wdata, 32'hAAAA0001);
    end
    sb.mem_ack = 1'b1;
    tick();
    sb.mem_ack = 1'b0;
    #1;
    chk("s1_count_after_ack", count, 0);
    chk("s1_empty_after_ack", empty, 1);
    chk("s1_seen_n", seen_addr.size(), 1);
    if (seen_addr.size() > 0) chk("s1_seen_addr", seen_addr[0], 32'h10);

    // Fill to full, stall, then push+ack in the same cycle
    seen_addr.delete(); seen_data.delete();
    for (int i = 0; i < 4; i++) begin
      sb.MemWriteM = 1'b1; sb.DataAdrM = 32'h100 + 32'(4*i); sb.WriteDataM = 32'hB0 + 32'(i);
      #1;
      chk("fill_stall", sb.StallM, 0);
      tick();
    end
    sb.DataAdrM = 32'h110; sb.WriteDataM = 32'hB4;
    #1;
    chk("full_count", count, 4);
    chk("full_stall", sb.StallM, 1);
    tick();
    chk("full_stall_hold", sb.StallM, 1);
    chk("full_count_hold", count, 4);
    sb.mem_ack = 1'b1;
    #1;
    chk("full_pushpop_stall", sb.StallM, 1);
    tick();
    sb.mem_ack = 1'b0;
    #1;
    chk("after_pop_count", count, 3);
    chk("after_pop_stall", sb.StallM, 0);
    chk("after_pop_addr", sb.mem_addr, 32'h104);
    tick();
    sb.MemWriteM = 1'b0;
    #1;
    chk("fifth_accepted_count", count, 4);
    sb.mem_ack = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    sb.mem_ack = 1'b0;
    #1;
    chk("full_drain_count", count, 0);
    chk("full_seen_n", seen_addr.size(), 5);
    for (int i = 0; i < 5; i++) begin
      if (i < seen_addr.size()) begin
        chk("full_seen_addr", seen_addr[i], 64'h100 + 64'(4*i));
        chk("full_seen_data", seen_data[i], 64'hB0 + 64'(i));
      end
    end

    // Forwarding
    sb.MemWriteM = 1'b1; sb.DataAdrM = 32'h20; sb.WriteDataM = 32'h1;
    tick();
    sb.WriteDataM = 32'h2;
    tick();
    sb.MemWriteM = 1'b0; sb.MemReadM = 1'b1; sb.DataAdrM = 32'h22;
    #1;
    chk("fwd_22_hit", sb.FwdHitM, 1);
    chk("fwd_22_data", sb.FwdDataM, 32'h2);
    sb.DataAdrM = 32'h24;
    #1;
    chk("fwd_24_hit", sb.FwdHitM, 0);
    chk("fwd_24_data", sb.FwdDataM, 0);
    sb.MemReadM = 1'b0; sb.DataAdrM = 32'h20;
    #1;
    chk("fwd_noread_hit", sb.FwdHitM, 0);
    chk("fwd_noread_data", sb.FwdDataM, 0);
    sb.MemWriteM = 1'b1; sb.MemReadM = 1'b1; sb.DataAdrM = 32'h30; sb.WriteDataM = 32'h3;
    #1;
    chk("fwd_samecycle_push_hit", sb.FwdHitM, 0);
    tick();
    sb.MemWriteM = 1'b0;
    #1;
    chk("fwd_30_hit", sb.FwdHitM, 1);
    chk("fwd_30_data", sb.FwdDataM, 32'h3);
    sb.mem_ack = 1'b1;
    tick();
    tick();
    chk("fwd_pop_count", count, 1);
    chk("fwd_popping_hit", sb.FwdHitM, 1);
    chk("fwd_popping_data", sb.FwdDataM, 32'h3);
    tick();
    sb.mem_ack = 1'b0;
    #1;
    chk("fwd_empty_hit", sb.FwdHitM, 0);
    chk("fwd_empty_count", count, 0);
    sb.MemReadM = 1'b0;

    // Eight stores, ack every other cycle, across pointer wrap
    seen_addr.delete(); seen_data.delete();
    sent = 0;
    for (int c = 0; c < 40; c++) begin
      sb.MemWriteM  = (sent < 8);
      sb.DataAdrM   = 32'(sent * 4);
      sb.WriteDataM = 32'hD0 + 32'(sent);
      sb.mem_ack    = c[0];
      #1;
      acc = sb.MemWriteM && !sb.StallM;
      tick();
      if (acc) sent++;
      if (sent == 8 && count == 0) break;
    end
    sb.MemWriteM = 1'b0; sb.mem_ack = 1'b0;
    #1;
    chk("wrap_sent", sent, 8);
    chk("wrap_count", count, 0);
    chk("wrap_empty", empty, 1);
    chk("wrap_seen_n", seen_addr.size(), 8);
    for (int i = 0; i < 8; i++) begin
      if (i < seen_addr.size()) begin
        chk("wrap_addr", seen_addr[i], 64'(4*i));
        chk("wrap_data", seen_data[i], 64'hD0 + 64'(i));
      end
    end

    // Reset with pending entries and an ack in the reset cycle
    for (int i = 0; i < 3; i++) begin
      sb.MemWriteM = 1'b1; sb.DataAdrM = 32'h40 + 32'(4*i); sb.WriteDataM = 32'hE0 + 32'(i);
      tick();
    end
    sb.MemWriteM = 1'b0;
    #1;
    chk("prerst_count", count, 3);
    seen_addr.delete(); seen_data.delete();
    reset = 1'b1; sb.mem_ack = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk("rst2_count", count, 0);
    chk("rst2_req", sb.mem_req, 0);
    chk("rst2_empty", empty, 1);
    for (int i = 0; i < 3; i++) tick();
    chk("ack_empty_count", count, 0);
    chk("rst2_no_writes", seen_addr.size(), 0);
    sb.mem_ack = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running expected=finished");
    $fatal(1);
  end
endmodule
